// File: rtl/nw_controller.sv
// -----------------------------------------------------------------------------
// nw_controller
// Sequencer for the Needleman-Wunsch datapath. It loads sequences A and B
// from the host into the symbol RAMs, initialises the score matrix, fills the
// matrix one cell at a time (read -> compute -> write -> advance) and then
// runs traceback. Every datapath enable/strobe is a registered output.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   start               begin a run (honoured only in IDLE/DONE/ERROR)
//   sym_valid/sym_data  host symbol stream (N symbols of A, then N of B)
//   sym_ready           controller accepts a symbol this cycle
//   end_init            datapath finished matrix initialisation
//   calculated          datapath finished the current cell
//   end_filling         datapath wrote the last cell
//   end_c               datapath finished traceback
//   din_ram, en_ram     symbol and enable towards the symbol RAMs
//   weA/weB, addr_dinA/addr_dinB  per-RAM write enable and address
//   en_init, en_read, en_ins, we, change_index, en_traceB  datapath strobes
//   busy, done, err     run status (err = cell timeout)
// -----------------------------------------------------------------------------
module nw_controller #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1),
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sym_valid,
    input  logic [2:0]       sym_data,
    output logic             sym_ready,
    input  logic             end_init,
    input  logic             calculated,
    input  logic             end_filling,
    input  logic             end_c,
    output logic [2:0]       din_ram,
    output logic             en_ram,
    output logic             weA,
    output logic             weB,
    output logic [BitAddr:0] addr_dinA,
    output logic [BitAddr:0] addr_dinB,
    output logic             en_init,
    output logic             en_read,
    output logic             en_ins,
    output logic             we,
    output logic             change_index,
    output logic             en_traceB,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int AW = BitAddr + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_INIT, S_RD, S_CALC,
        S_WR, S_NEXT, S_TRACE, S_DONE, S_ERROR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmo;
    logic            r_fill_seen;

    logic [2:0]      r_din;
    logic            r_en_ram, r_weA, r_weB;
    logic [AW-1:0]   r_addrA, r_addrB;
    logic            r_sym_ready, r_en_init, r_en_read, r_en_ins, r_we;
    logic            r_change_index, r_en_traceB, r_busy, r_done, r_err;

    logic            w_sym_ready, w_en_init, w_en_read, w_en_ins, w_we;
    logic            w_change_index, w_en_traceB, w_busy, w_done, w_err;

    logic            w_idle_like, w_start, w_accept, w_last, w_fill_phase, w_tmo_hit;

    assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    assign w_start      = start && w_idle_like;
    // sym_ready is high exactly while in LOAD_A/LOAD_B, so this is the handshake
    assign w_accept     = sym_valid && r_sym_ready;
    assign w_last       = (r_cnt == AW'(N - 1));
    assign w_fill_phase = (r_state == S_RD) || (r_state == S_CALC) ||
                          (r_state == S_WR) || (r_state == S_NEXT);
    assign w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LOAD_A;
            S_LOAD_A: if (w_accept && w_last) w_next = S_LOAD_B;
            S_LOAD_B: if (w_accept && w_last) w_next = S_INIT;
            S_INIT:   if (end_init) w_next = S_RD;
            S_RD:     w_next = S_CALC;
            S_CALC: begin
                if (calculated)     w_next = S_WR;
                else if (w_tmo_hit) w_next = S_ERROR;
            end
            S_WR:     w_next = S_NEXT;
            // end_filling may have pulsed earlier in this cell; the sticky flag keeps it
            S_NEXT:   w_next = (end_filling || r_fill_seen) ? S_TRACE : S_RD;
            S_TRACE:  if (end_c) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode from the next state; registered below so outputs track the state
    always_comb begin
        w_sym_ready    = (w_next == S_LOAD_A) || (w_next == S_LOAD_B);
        w_en_init      = (w_next == S_INIT);
        w_en_read      = (w_next == S_RD);
        w_en_ins       = (w_next == S_CALC);
        w_we           = (w_next == S_WR);
        w_change_index = (w_next == S_NEXT);
        w_en_traceB    = (w_next == S_TRACE);
        w_done         = (w_next == S_DONE);
        w_err          = (w_next == S_ERROR);
        w_busy         = !((w_next == S_IDLE) || (w_next == S_DONE) || (w_next == S_ERROR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sym_ready    <= 1'b0;
            r_en_init      <= 1'b0;
            r_en_read      <= 1'b0;
            r_en_ins       <= 1'b0;
            r_we           <= 1'b0;
            r_change_index <= 1'b0;
            r_en_traceB    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_sym_ready    <= w_sym_ready;
            r_en_init      <= w_en_init;
            r_en_read      <= w_en_read;
            r_en_ins       <= w_en_ins;
            r_we           <= w_we;
            r_change_index <= w_change_index;
            r_en_traceB    <= w_en_traceB;
            r_busy         <= w_busy;
            r_done         <= w_done;
            r_err          <= w_err;
        end
    end

    // Symbol write path, load counter, cell timeout and end_filling latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din       <= '0;
            r_en_ram    <= 1'b0;
            r_weA       <= 1'b0;
            r_weB       <= 1'b0;
            r_addrA     <= '0;
            r_addrB     <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_fill_seen <= 1'b0;
        end else begin
            r_en_ram <= w_accept;
            r_weA    <= w_accept && (r_state == S_LOAD_A);
            r_weB    <= w_accept && (r_state == S_LOAD_B);
            if (w_accept) begin
                r_din <= sym_data;
                if (r_state == S_LOAD_A) r_addrA <= r_cnt;
                else                     r_addrB <= r_cnt;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end

            if (r_state == S_CALC && !calculated) r_tmo <= r_tmo + 1'b1;
            if (r_state == S_NEXT)                r_tmo <= '0;

            if (w_fill_phase && end_filling)           r_fill_seen <= 1'b1;
            if (r_state == S_NEXT && w_next == S_TRACE) r_fill_seen <= 1'b0;

            if (w_start) begin
                r_cnt       <= '0;
                r_tmo       <= '0;
                r_fill_seen <= 1'b0;
                r_addrA     <= '0;
                r_addrB     <= '0;
            end
        end
    end

    assign sym_ready    = r_sym_ready;
    assign din_ram      = r_din;
    assign en_ram       = r_en_ram;
    assign weA          = r_weA;
    assign weB          = r_weB;
    assign addr_dinA    = r_addrA;
    assign addr_dinB    = r_addrB;
    assign en_init      = r_en_init;
    assign en_read      = r_en_read;
    assign en_ins       = r_en_ins;
    assign we           = r_we;
    assign change_index = r_change_index;
    assign en_traceB    = r_en_traceB;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule
